regfile_read_stage: RTL and testbench

Operand-read stage paired with the 32×64 register array; it is the reader end of the array's write interface. Each cycle it accepts at most one request naming two source registers and an optional destination. It reads both operands from the array outputs, bypasses same-cycle writebacks, and tracks pending writes in a 32-bit scoreboard. Read-after-write and write-after-write hazards stall the request until the producer writes back. Operands are delivered through a one-entry registered output stage with a valid/ready handshake.

---
 rtl/regfile_read_stage.sv | 144 ++++++++++++++
 tb/tb_regfile_read_stage.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_read_stage.sv
// Operand-read stage for the 32-entry register array: bypass, busy scoreboard, one-entry output.
// Optional feature: define RF_READ_STALL_CNT_EN to implement the saturating hazard-stall counter.
module regfile_read_stage #(
  parameter int WIDTH    = 64,
  parameter int ZERO_REG = 31
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [31:0][WIDTH-1:0] regs_in,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [4:0]             req_ra,
  input  logic [4:0]             req_rb,
  input  logic [4:0]             req_rd,
  input  logic                   req_rd_en,
  input  logic                   wb_en,
  input  logic [4:0]             wb_addr,
  input  logic [WIDTH-1:0]       wb_data,
  input  logic                   flush,
  output logic                   op_valid,
  input  logic                   op_ready,
  output logic [WIDTH-1:0]       op_a,
  output logic [WIDTH-1:0]       op_b,
  output logic [4:0]             op_rd,
  output logic                   op_rd_en,
  output logic [31:0]            busy,
  output logic [15:0]            stall_cnt
);

  localparam logic [4:0] ZERO_IDX = 5'(ZERO_REG);

  typedef enum logic {S_EMPTY, S_FULL} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] op_a_q, op_b_q;
  logic [4:0]       op_rd_q;
  logic             op_rd_en_q;
  logic [31:0]      busy_q, busy_d;

  logic             byp_a, byp_b, byp_rd;
  logic [WIDTH-1:0] val_a, val_b;
  logic             hazard, accept, load;

  // A writeback in flight this cycle both supplies the operand and releases its busy bit.
  always_comb begin
    byp_a  = wb_en && (wb_addr == req_ra);
    byp_b  = wb_en && (wb_addr == req_rb);
    byp_rd = wb_en && (wb_addr == req_rd);
    val_a  = (req_ra == ZERO_IDX) ? '0 : (byp_a ? wb_data : regs_in[req_ra]);
    val_b  = (req_rb == ZERO_IDX) ? '0 : (byp_b ? wb_data : regs_in[req_rb]);
    hazard = (busy_q[req_ra] && !byp_a)
          || (busy_q[req_rb] && !byp_b)
          || (req_rd_en && busy_q[req_rd] && !byp_rd);
  end

  assign req_ready = req_valid && !flush && !hazard && (!op_valid || op_ready);
  assign accept    = req_ready;

  // NOTE: every variable written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    unique case (state_q)
      S_EMPTY: begin
        if (accept) begin
          state_d = S_FULL;
          load    = 1'b1;
        end
      end
      S_FULL: begin
        if (accept) begin
          load = 1'b1;
        end else if (op_ready) begin
          state_d = S_EMPTY;
        end
      end
      default: state_d = S_EMPTY;
    endcase
    if (flush) state_d = S_EMPTY;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_EMPTY;
    else        state_q <= state_d;
  end

  // The operand payload is reset too, so no stale entry is visible after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_a_q     <= '0;
      op_b_q     <= '0;
      op_rd_q    <= '0;
      op_rd_en_q <= 1'b0;
    end else if (load) begin
      op_a_q     <= val_a;
      op_b_q     <= val_b;
      op_rd_q    <= req_rd;
      op_rd_en_q <= req_rd_en;
    end
  end

  assign op_valid = (state_q == S_FULL);
  assign op_a     = op_a_q;
  assign op_b     = op_b_q;
  assign op_rd    = op_rd_q;
  assign op_rd_en = op_rd_en_q;

  // Clears are applied before the set so a new claim wins over a same-index writeback.
  always_comb begin
    busy_d = busy_q;
    if (wb_en) busy_d[wb_addr] = 1'b0;
    if (flush && op_valid && op_rd_en_q) busy_d[op_rd_q] = 1'b0;
    if (accept && req_rd_en && (req_rd != ZERO_IDX)) busy_d[req_rd] = 1'b1;
    busy_d[ZERO_IDX] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  assign busy = busy_q;

`ifdef RF_READ_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (req_valid && hazard && !flush && (stall_cnt_q != 16'hFFFF))
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_regfile_read_stage.sv
// Randomized self-checking bench for regfile_read_stage against a behavioural operand/scoreboard model.
// Honours RF_READ_STALL_CNT_EN the same way as the design (long saturation run only when defined).
module tb_regfile_read_stage;

  localparam int         W  = 64;
  localparam logic [4:0] ZR = 5'd31;

  logic                clk;
  logic                reset;
  logic [31:0][W-1:0]  regs_in;
  logic                req_valid, req_ready;
  logic [4:0]          req_ra, req_rb, req_rd;
  logic                req_rd_en;
  logic                wb_en;
  logic [4:0]          wb_addr;
  logic [W-1:0]        wb_data;
  logic                flush;
  logic                op_valid, op_ready;
  logic [W-1:0]        op_a, op_b;
  logic [4:0]          op_rd;
  logic                op_rd_en;
  logic [31:0]         busy;
  logic [15:0]         stall_cnt;

  regfile_read_stage #(.WIDTH(W), .ZERO_REG(31)) dut (
    .clk(clk), .reset(reset), .regs_in(regs_in),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_ra(req_ra), .req_rb(req_rb), .req_rd(req_rd), .req_rd_en(req_rd_en),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .flush(flush), .op_valid(op_valid), .op_ready(op_ready),
    .op_a(op_a), .op_b(op_b), .op_rd(op_rd), .op_rd_en(op_rd_en),
    .busy(busy), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         v;
    bit [4:0]   ra, rb, rd;
    bit         rd_en;
    bit         wb_en;
    bit [4:0]   wb_addr;
    logic [63:0] wb_data;
    bit         flush;
    bit         op_ready;
  } stim_t;

  int total = 0;
  int bad   = 0;

  // Reference model: pending-write set, one output slot, stall count.
  bit          pend [32];
  bit          m_ov;
  logic [63:0] m_a, m_b;
  bit [4:0]    m_rd;
  bit          m_rd_en;
  int          m_cnt;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] m_src(input bit [4:0] s, input stim_t st);
    if (s == ZR) return 64'd0;
    if (st.wb_en && st.wb_addr == s) return st.wb_data;
    return regs_in[s];
  endfunction

  function automatic bit m_wait(input bit [4:0] s, input stim_t st);
    return pend[s] && !(st.wb_en && st.wb_addr == s);
  endfunction

  function automatic bit m_hazard(input stim_t st);
    return m_wait(st.ra, st) || m_wait(st.rb, st) || (st.rd_en && m_wait(st.rd, st));
  endfunction

  function automatic logic [31:0] m_busy();
    logic [31:0] b = '0;
    for (int i = 0; i < 32; i++) b[i] = pend[i];
    return b;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) pend[i] = 1'b0;
    m_ov = 0; m_a = '0; m_b = '0; m_rd = '0; m_rd_en = 0; m_cnt = 0;
  endtask

  task automatic drive_idle();
    req_valid = 0; req_ra = '0; req_rb = '0; req_rd = '0; req_rd_en = 0;
    wb_en = 0; wb_addr = '0; wb_data = '0; flush = 0; op_ready = 0;
  endtask

  task automatic check_outputs(input string pfx);
    check({pfx, ".op_valid"},  op_valid,  m_ov);
    check({pfx, ".busy"},      busy,      m_busy());
    check({pfx, ".stall_cnt"}, stall_cnt, m_cnt);
    if (m_ov) begin
      check({pfx, ".op_a"},     op_a,     m_a);
      check({pfx, ".op_b"},     op_b,     m_b);
      check({pfx, ".op_rd"},    op_rd,    m_rd);
      check({pfx, ".op_rd_en"}, op_rd_en, m_rd_en);
    end
  endtask

  // Called one time unit after a rising edge; leaves off one time unit after the next.
  task automatic step(input stim_t st, input bit chk);
    bit er;
    req_valid = st.v;  req_ra = st.ra; req_rb = st.rb; req_rd = st.rd; req_rd_en = st.rd_en;
    wb_en = st.wb_en;  wb_addr = st.wb_addr; wb_data = st.wb_data;
    flush = st.flush;  op_ready = st.op_ready;
    #1;
    er = st.v && !st.flush && !m_hazard(st) && (!m_ov || st.op_ready);
    if (chk) check("req_ready", req_ready, er);
    @(posedge clk);
`ifdef RF_READ_STALL_CNT_EN
    if (st.v && m_hazard(st) && !st.flush && m_cnt < 16'hFFFF) m_cnt++;
`endif
    if (st.flush) begin
      if (m_ov && m_rd_en) pend[m_rd] = 1'b0;
      m_ov = 0;
    end
    if (st.wb_en) pend[st.wb_addr] = 1'b0;
    if (er) begin
      m_a = m_src(st.ra, st); m_b = m_src(st.rb, st);
      m_rd = st.rd; m_rd_en = st.rd_en; m_ov = 1;
      if (st.rd_en && st.rd != ZR) pend[st.rd] = 1'b1;
    end else if (st.op_ready) begin
      m_ov = 0;
    end
    if (st.wb_en) regs_in[st.wb_addr] = st.wb_data;
    #1;
    if (chk) check_outputs("cyc");
  endtask

  function automatic stim_t req(input bit [4:0] ra, input bit [4:0] rb, input bit [4:0] rd,
                                input bit rd_en, input bit op_rdy);
    stim_t s;
    s.v = 1; s.ra = ra; s.rb = rb; s.rd = rd; s.rd_en = rd_en;
    s.wb_en = 0; s.wb_addr = '0; s.wb_data = '0; s.flush = 0; s.op_ready = op_rdy;
    return s;
  endfunction

  function automatic bit [4:0] pick_idx();
    int r = $urandom_range(0, 9);
    return (r == 9) ? ZR : 5'(r);
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    bit [4:0] q [$];
    s.v = ($urandom_range(0, 9) < 8);
    s.ra = pick_idx(); s.rb = pick_idx(); s.rd = pick_idx();
    s.rd_en = $urandom_range(0, 1);
    s.wb_en = ($urandom_range(0, 9) < 4);
    for (int i = 0; i < 32; i++) if (pend[i]) q.push_back(5'(i));
    if (q.size() != 0 && $urandom_range(0, 3) != 0) s.wb_addr = q[$urandom_range(0, q.size() - 1)];
    else s.wb_addr = pick_idx();
    s.wb_data = {$urandom, $urandom};
    s.flush = ($urandom_range(0, 19) == 0);
    s.op_ready = ($urandom_range(0, 9) < 7);
    return s;
  endfunction

  initial begin
    stim_t s;
    reset = 0;
    drive_idle();
    for (int i = 0; i < 32; i++) regs_in[i] = {$urandom, $urandom};
    regs_in[3]  = 64'd5;
    regs_in[31] = 64'hDEAD_BEEF_0000_0031;
    model_reset();
    #1;
    check("rst.op_valid", op_valid, 1'b0);
    check("rst.busy", busy, 32'd0);
    check("rst.op_a", op_a, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1;
    @(posedge clk); #1;

    // Zero register reads 0 even though the array holds a nonzero value there.
    step(req(5'd3, ZR, 5'd0, 1'b0, 1'b1), 1'b1);
    check("t1.op_a", op_a, 64'd5);
    check("t1.op_b", op_b, 64'd0);

    // RAW stall on r7, released by same-cycle writeback bypass.
    step(req(5'd0, 5'd1, 5'd7, 1'b1, 1'b1), 1'b1);
    step(req(5'd7, 5'd1, 5'd2, 1'b0, 1'b1), 1'b1);
    check("t2.stalled", req_ready, 1'b0);
    check("t2.busy7", busy[7], 1'b1);
    s = req(5'd7, 5'd1, 5'd2, 1'b0, 1'b1);
    s.wb_en = 1; s.wb_addr = 5'd7; s.wb_data = 64'h1234;
    step(s, 1'b1);
    check("t2.op_a", op_a, 64'h1234);
    check("t2.busy7", busy[7], 1'b0);

    // Backpressure: output holds for four cycles, then back-to-back accepts.
    step(req(5'd1, 5'd2, 5'd0, 1'b0, 1'b0), 1'b1);
    for (int i = 0; i < 4; i++) step(req(5'd4, 5'd5, 5'd0, 1'b0, 1'b0), 1'b1);
    for (int i = 0; i < 3; i++) step(req(5'(i), 5'(i + 1), 5'd0, 1'b0, 1'b1), 1'b1);

    // Zero destination never marked busy; set wins over same-index clear.
    step(req(5'd0, 5'd0, ZR, 1'b1, 1'b1), 1'b1);
    check("t4.busy_zero", busy, 32'd0);
    s = req(5'd0, 5'd0, 5'd9, 1'b1, 1'b1);
    s.wb_en = 1; s.wb_addr = 5'd9; s.wb_data = 64'h99;
    step(s, 1'b1);
    check("t4.busy9", busy[9], 1'b1);

    // Flush of a full entry releases its destination.
    step(req(5'd0, 5'd1, 5'd4, 1'b1, 1'b0), 1'b1);
    s = req(5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
    s.v = 0; s.flush = 1;
    step(s, 1'b1);
    check("t5.op_valid", op_valid, 1'b0);
    check("t5.busy4", busy[4], 1'b0);

    // Asynchronous reset while stalled on r9.
    req_valid = 1; req_ra = 5'd9; req_rb = 5'd0; req_rd_en = 0; op_ready = 1;
    #3 reset = 0;
    #1;
    check("arst.op_valid", op_valid, 1'b0);
    check("arst.busy", busy, 32'd0);
    check("arst.stall_cnt", stall_cnt, 16'd0);
    check("arst.op_a", op_a, 64'd0);
    check("arst.op_rd_en", op_rd_en, 1'b0);
    drive_idle();
    model_reset();
    @(negedge clk) reset = 1;
    @(posedge clk); #1;

    for (int i = 0; i < 3000; i++) step(rand_stim(), 1'b1);

`ifdef RF_READ_STALL_CNT_EN
    // Hold a hazard long enough to saturate the stall counter.
    s = req(5'd0, 5'd0, 5'd5, 1'b1, 1'b1);
    s.wb_en = 1; s.wb_addr = 5'd5; s.wb_data = 64'h5;
    step(s, 1'b1);
    for (int i = 0; i < 65540; i++) step(req(5'd5, 5'd0, 5'd0, 1'b0, 1'b1), 1'b0);
    check("sat.stall_cnt", stall_cnt, 16'hFFFF);
    check_outputs("sat");
`else
    step(req(5'd0, 5'd0, 5'd5, 1'b1, 1'b1), 1'b1);
    for (int i = 0; i < 200; i++) step(req(5'd5, 5'd0, 5'd0, 1'b0, 1'b1), 1'b0);
    check("nocnt.stall_cnt", stall_cnt, 16'd0);
    check_outputs("nocnt");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
